// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounced push-button front-end that edits a BCD hour/minute
// value in two fields and strobes load so the time keeper adopts it.
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TIMEOUT_CYCLES  = 750000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [3:0] cur_ms_hour,
    input  logic [3:0] cur_ls_hour,
    input  logic [3:0] cur_ms_min,
    input  logic [3:0] cur_ls_min,
    output logic [3:0] set_ms_hour,
    output logic [3:0] set_ls_hour,
    output logic [3:0] set_ms_min,
    output logic [3:0] set_ls_min,
    output logic       load,
    output logic       setting,
    output logic [1:0] field
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, SET_HOUR, SET_MIN, COMMIT} state_t;
    state_t state, nxt;
    logic [2:0] raw, s1, s2, deb, hit, rise;
    logic [DW-1:0] cnt [3];
    logic [TW-1:0] tcnt;
    logic m, u, d, acc, tmo;
    logic [7:0] nh, nm;

    function automatic logic [7:0] hr_inc(input logic [7:0] h);
        if (h[7:4] > 4'd2 || h[3:0] > 4'd9 || (h[7:4] == 4'd2 && h[3:0] >= 4'd3)) return 8'h00;
        return h[3:0] == 4'd9 ? {h[7:4] + 4'd1, 4'd0} : {h[7:4], h[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] hr_dec(input logic [7:0] h);
        if (h[7:4] > 4'd2 || h[3:0] > 4'd9 || (h[7:4] == 4'd2 && h[3:0] > 4'd3) || h == 8'h00) return 8'h23;
        return h[3:0] == 4'd0 ? {h[7:4] - 4'd1, 4'd9} : {h[7:4], h[3:0] - 4'd1};
    endfunction

    function automatic logic [7:0] mn_inc(input logic [7:0] v);
        if (v[7:4] > 4'd5 || v[3:0] > 4'd9 || v == 8'h59) return 8'h00;
        return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] mn_dec(input logic [7:0] v);
        if (v[7:4] > 4'd5 || v[3:0] > 4'd9 || v == 8'h00) return 8'h59;
        return v[3:0] == 4'd0 ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign raw = {btn_mode, btn_up, btn_down};

    always_comb begin
        hit = '0;
        for (int i = 0; i < 3; i++) hit[i] = cnt[i] == DW'(DEBOUNCE_CYCLES - 1);
    end

    // A press is the cycle in which the debounced level is about to rise.
    assign rise = hit & s2 & ~deb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1  <= '0;
            s2  <= '0;
            deb <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == deb[i]) cnt[i] <= '0;
                else if (hit[i]) begin
                    cnt[i] <= '0;
                    deb[i] <= s2[i];
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    assign m   = rise[2];
    assign u   = rise[1] & ~rise[0] & ~m;
    assign d   = rise[0] & ~rise[1] & ~m;
    assign acc = m | u | d;
    assign tmo = tcnt == TW'(TIMEOUT_CYCLES - 1);

    assign load    = state == COMMIT;
    assign setting = state == SET_HOUR || state == SET_MIN;
    assign field   = state == SET_HOUR ? 2'b01 : state == SET_MIN ? 2'b10 : 2'b00;

    always_comb begin
        nxt = state;
        nh  = {set_ms_hour, set_ls_hour};
        nm  = {set_ms_min, set_ls_min};
        case (state)
            IDLE: begin
                nh = {cur_ms_hour, cur_ls_hour};
                nm = {cur_ms_min, cur_ls_min};
                if (m) nxt = SET_HOUR;
            end
            SET_HOUR: begin
                if (m) nxt = SET_MIN;
                else if (u) nh = hr_inc(nh);
                else if (d) nh = hr_dec(nh);
                else if (tmo) nxt = IDLE;
            end
            SET_MIN: begin
                if (m) nxt = COMMIT;
                else if (u) nm = mn_inc(nm);
                else if (d) nm = mn_dec(nm);
                else if (tmo) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            tcnt  <= '0;
            {set_ms_hour, set_ls_hour} <= '0;
            {set_ms_min, set_ls_min}   <= '0;
        end else begin
            state <= nxt;
            tcnt  <= (setting && !acc && !tmo) ? tcnt + 1'b1 : '0;
            {set_ms_hour, set_ls_hour} <= nh;
            {set_ms_min, set_ls_min}   <= nm;
        end
    end
endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Front-end for setting the alarm clock time from the board push-buttons.
- Synchronizes and debounces raw buttons, then runs a field-select FSM (hours, then minutes). Edits BCD hour and minute digits with wrap-around and issues a one-cycle load strobe, so the time register in the top-level controller takes the new value.
- Data flows in the opposite direction to the display path: buttons in, BCD time out.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable clk cycles required to accept a button level change (10 ms at 25 MHz).
- TIMEOUT_CYCLES, 750000000: clk cycles with no accepted press before set mode is abandoned (30 s at 25 MHz).

Ports:
- clk  in  1  system clock (MCLK domain)
- reset  in  1  asynchronous, active-high reset
- btn_mode  in  1  raw async button: enter set mode / advance field / commit
- btn_up  in  1  raw async button: increment selected field
- btn_down  in  1  raw async button: decrement selected field
- cur_ms_hour, cur_ls_hour, cur_ms_min, cur_ls_min  in  4 each  current running time, BCD
- set_ms_hour, set_ls_hour, set_ms_min, set_ls_min  out  4 each  edited time, BCD, registered
- load  out  1  one-cycle strobe: set_* valid, controller must overwrite its time
- setting  out  1  high while in SET_HOUR or SET_MIN
- field  out  2  00 = none, 01 = hours, 10 = minutes (for display blanking/blink)

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; synchronizers, debounced levels, debounce counters and timeout counter all 0.
- Input conditioning, per button:
  - 2-FF synchronizer.
  - Counter clears whenever the synchronized level equals the debounced level. Otherwise it counts, and when it reaches DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
  - Press event = one-cycle pulse on a debounced 0->1 transition. No event on release.
- Press timing: press-event latency from a clean raw edge is DEBOUNCE_CYCLES+2 clk cycles (±1). A button held through reset release produces exactly one press after that latency.
- Simultaneous up and down events in the same cycle: both are ignored. A mode event in the same cycle as up/down: mode wins, and up/down are ignored.
- FSM states: IDLE, SET_HOUR, SET_MIN, COMMIT.
  - IDLE: set_* follow cur_* with 1-cycle register delay. The mode event snapshots cur_* into set_* and moves to SET_HOUR. up/down are ignored.
  - SET_HOUR: up/down edit the hour field (00-23). The mode event moves to SET_MIN.
  - SET_MIN: up/down edit the minute field (00-59). The mode event moves to COMMIT.
  - COMMIT: load=1 for exactly one cycle, set_* held stable, then IDLE. Presses arriving during COMMIT are dropped.
- Timeout: in SET_HOUR/SET_MIN the counter increments each cycle and clears on any accepted press event. At TIMEOUT_CYCLES-1 the FSM returns to IDLE with no load; set_* resume tracking cur_*.
- setting=1 and field=01 in SET_HOUR; setting=1 and field=10 in SET_MIN; otherwise setting=0 and field=00.
- Arithmetic (pure BCD, each digit is always 0-9):
  - Hour increment: 23->00, x9->(x+1)0, else ls+1.
  - Hour decrement: 00->23, x0->(x-1)9, else ls-1.
  - Minute increment: 59->00, ls 9 -> ms+1 with ls 0. Minute decrement: 00->59.
  - Non-selected field is never modified.
  - Out-of-range snapshot (hour >23, minute >59, or any digit >9): increment yields 00; decrement yields the maximum (23 or 59).
- Update latency: set_* change on the clk edge after the press-event cycle.
- Reset mid-operation (any state, including COMMIT): immediate return to reset values; load is never emitted.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64):
- Bounce: btn_up toggles every 2 cycles for 20 cycles, then holds 1, while in SET_HOUR at 07 -> exactly one increment, set hour = 08.
- Hour wrap: cur=23:59; mode, up -> set hour 00; down, down -> 22. mode, mode -> load pulse 1 cycle with set=22:59. FSM back in IDLE, setting=0.
- Minute carry/borrow: SET_MIN at 09, up -> 10; at 00, down -> 59. Hour field unchanged throughout.
- Timeout: enter SET_MIN from 12:34, edit to 12:35, then idle 64 cycles -> setting=0, no load, set_* = cur_* within 2 cycles.
- Conflicts: up and down events in the same cycle in SET_HOUR at 05 -> stays 05. Mode and up in the same cycle -> field advances to minutes with no increment.
- Reset: assert reset for 1 cycle in SET_MIN -> all outputs 0 and state IDLE. With btn_mode held across reset release -> one mode event after 6±1 cycles, entering SET_HOUR.
